uart_rx_fifo: RTL and testbench

Receive-side byte buffer between one `uart` engine and the Wishbone UART register block. It drains received bytes from the engine using the engine's `rx_avail`/`rx_ack` handshake and stores each byte with its error flag in a FIFO. Toward the register block it presents the same `rx_data`/`rx_avail`/`rx_error`/`rx_ack` contract, so it drops in transparently. Its purpose is to stop the Z80 monitor from losing characters during pasted input at 115200 baud.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART engine and the register block; one-cycle push/pop latency, show-ahead head.
// Full: back-pressures the engine, or with UART_RXFIFO_DROP_EN acks and discards the byte and sets sticky overrun.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            up_data,
   input  logic                  up_avail,
   input  logic                  up_error,
   output logic                  up_ack,
   output logic [7:0]            rx_data,
   output logic                  rx_avail,
   output logic                  rx_error,
   input  logic                  rx_ack,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  err_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {IDLE, WAIT_LOW} state_t;

   state_t                 state_q, state_d;
   logic                   up_ack_q, up_ack_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]    count_q, count_d;
   logic                   overrun_q, overrun_d;
   logic [8:0]             mem_q [DEPTH];
   logic [8:0]             head;
   logic                   push, pop, drop, full, empty;

   assign empty = (count_q == '0);
   // count never exceeds DEPTH, so its MSB alone marks full
   assign full  = count_q[DEPTH_LOG2];
   assign pop   = rx_ack & ~empty;

   always_comb begin
      state_d  = state_q;
      up_ack_d = 1'b0;
      push     = 1'b0;
      drop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (up_avail) begin
               if (!full || pop) begin
                  push     = 1'b1;
                  up_ack_d = 1'b1;
                  state_d  = WAIT_LOW;
               end
`ifdef UART_RXFIFO_DROP_EN
               else begin
                  drop     = 1'b1;
                  up_ack_d = 1'b1;
                  state_d  = WAIT_LOW;
               end
`endif
            end
         end
         WAIT_LOW: begin
            if (!up_avail) state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
`ifdef UART_RXFIFO_DROP_EN
      // a drop in the same cycle as a clear keeps the flag set
      overrun_d = drop | (overrun_q & ~err_clr);
`else
      overrun_d = drop;
`endif
   end

`ifndef UART_RXFIFO_DROP_EN
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         up_ack_q  <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         up_ack_q  <= up_ack_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {up_error, up_data};
   end

   // stale memory stays hidden while empty so the outputs read zero after reset
   assign head     = empty ? 9'h000 : mem_q[rd_ptr_q];
   assign rx_data  = head[7:0];
   assign rx_error = head[8];
   assign rx_avail = ~empty;
   assign up_ack   = up_ack_q;
   assign count    = count_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus hand sequences, scoreboard queue of expected entries.
module tb_uart_rx_fifo;

   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [7:0]     up_data;
   logic           up_avail;
   logic           up_error;
   logic           up_ack;
   logic [7:0]     rx_data;
   logic           rx_avail;
   logic           rx_error;
   logic           rx_ack;
   logic [DL2:0]   count;
   logic           overrun;
   logic           err_clr;

   uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
      .clk      (clk),
      .reset    (reset),
      .up_data  (up_data),
      .up_avail (up_avail),
      .up_error (up_error),
      .up_ack   (up_ack),
      .rx_data  (rx_data),
      .rx_avail (rx_avail),
      .rx_error (rx_error),
      .rx_ack   (rx_ack),
      .count    (count),
      .overrun  (overrun),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic       pop;
      logic [7:0] d;
      logic       e;
      int         cnt;
      logic       avail;
   } vec_t;

   vec_t       vecs [10];
   logic [8:0] sb [$];
   int         n_chk  = 0;
   int         n_pass = 0;

   function automatic vec_t mk(input logic pu, input logic po, input logic [7:0] d,
                               input logic e, input int c, input logic a);
      vec_t v;
      v.push = pu; v.pop = po; v.d = d; v.e = e; v.cnt = c; v.avail = a;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Engine model: hold avail until acked (bounded), then drop it for one cycle.
   task automatic send_byte(input logic [7:0] d, input logic e, input string name);
      bit got;
      got = 1'b0;
      sb.push_back({e, d});
      up_data  = d;
      up_error = e;
      up_avail = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = up_ack;
      end
      chk({name, "_ack"}, 32'(got), 32'(1));
      up_avail = 1'b0;
      @(negedge clk);
      chk({name, "_ackw"}, 32'(up_ack), 32'(0));
   endtask

   task automatic pop_chk(input string name);
      logic [8:0] e;
      e = 9'h1FF;
      if (sb.size() != 0) e = sb.pop_front();
      chk({name, "_avail"}, 32'(rx_avail), 32'(1));
      chk({name, "_dat"}, 32'(rx_data), 32'(e[7:0]));
      chk({name, "_err"}, 32'(rx_error), 32'(e[8]));
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      logic [8:0] e;
      string nm;
      nm = $sformatf("vec%0d", idx);
      if (v.pop) begin
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({nm, "_dat"}, 32'(rx_data), 32'(e[7:0]));
            chk({nm, "_err"}, 32'(rx_error), 32'(e[8]));
         end else begin
            chk({nm, "_empty"}, 32'(rx_avail), 32'(0));
         end
      end
      if (v.push) sb.push_back({v.e, v.d});
      up_data  = v.d;
      up_error = v.e;
      up_avail = v.push;
      rx_ack   = v.pop;
      @(negedge clk);
      if (v.push) chk({nm, "_ack"}, 32'(up_ack), 32'(1));
      up_avail = 1'b0;
      rx_ack   = 1'b0;
      @(negedge clk);
      chk({nm, "_cnt"}, 32'(count), 32'(v.cnt));
      chk({nm, "_rxav"}, 32'(rx_avail), 32'(v.avail));
   endtask

   initial begin
      bit got;
      int pulses;

      vecs[0] = mk(1'b1, 1'b0, 8'h41, 1'b0, 1, 1'b1);
      vecs[1] = mk(1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);
      vecs[2] = mk(1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);  // pop on empty is ignored
      vecs[3] = mk(1'b1, 1'b0, 8'h11, 1'b0, 1, 1'b1);
      vecs[4] = mk(1'b1, 1'b0, 8'h22, 1'b0, 2, 1'b1);
      vecs[5] = mk(1'b1, 1'b0, 8'h33, 1'b0, 3, 1'b1);
      vecs[6] = mk(1'b1, 1'b1, 8'h7E, 1'b1, 3, 1'b1);  // simultaneous push and pop
      vecs[7] = mk(1'b0, 1'b1, 8'h00, 1'b0, 2, 1'b1);
      vecs[8] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1, 1'b1);
      vecs[9] = mk(1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);

      reset    = 1'b0;
      up_data  = 8'h00;
      up_avail = 1'b0;
      up_error = 1'b0;
      rx_ack   = 1'b0;
      err_clr  = 1'b0;
      #12;
      chk("rst_ack", 32'(up_ack), 32'(0));
      chk("rst_avail", 32'(rx_avail), 32'(0));
      chk("rst_data", 32'(rx_data), 32'(0));
      chk("rst_err", 32'(rx_error), 32'(0));
      chk("rst_cnt", 32'(count), 32'(0));
      chk("rst_ovr", 32'(overrun), 32'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single byte with avail held high for 10 cycles after the ack.
      sb.push_back({1'b0, 8'h41});
      up_data  = 8'h41;
      up_error = 1'b0;
      up_avail = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = up_ack;
      end
      chk("single_ack", 32'(got), 32'(1));
      chk("single_cnt", 32'(count), 32'(1));
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (up_ack) pulses++;
      end
      chk("held_pulses", 32'(pulses), 32'(0));
      chk("held_cnt", 32'(count), 32'(1));
      up_avail = 1'b0;
      @(negedge clk);
      pop_chk("single_pop");
      chk("single_cnt0", 32'(count), 32'(0));
      chk("single_avail0", 32'(rx_avail), 32'(0));

      for (int i = 0; i < 10; i++) apply(vecs[i], i);

      // Fill across the pointer wrap.
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, $sformatf("fill%0d", i));
      chk("full_cnt", 32'(count), 32'(DEPTH));
`ifdef UART_RXFIFO_DROP_EN
      up_data  = 8'h55;
      up_error = 1'b0;
      up_avail = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = up_ack;
      end
      chk("drop_ack", 32'(got), 32'(1));
      up_avail = 1'b0;
      @(negedge clk);
      chk("drop_ovr", 32'(overrun), 32'(1));
      chk("drop_cnt", 32'(count), 32'(DEPTH));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_ovr", 32'(overrun), 32'(0));
      for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("drain%0d", i));
`else
      up_data  = 8'h10;
      up_error = 1'b0;
      up_avail = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (up_ack) pulses++;
      end
      chk("bp_noack", 32'(pulses), 32'(0));
      chk("bp_cnt", 32'(count), 32'(DEPTH));
      chk("bp_ovr", 32'(overrun), 32'(0));
      pop_chk("bp_pop");
      chk("bp_accept", 32'(up_ack), 32'(1));
      sb.push_back({1'b0, 8'h10});
      up_avail = 1'b0;
      @(negedge clk);
      chk("bp_cnt2", 32'(count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("drain%0d", i));
`endif
      chk("drain_cnt", 32'(count), 32'(0));
      chk("drain_avail", 32'(rx_avail), 32'(0));

      // Asynchronous reset with five entries held and up_ack high.
      for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0, $sformatf("pre%0d", i));
      up_data  = 8'hA4;
      up_avail = 1'b1;
      @(posedge clk);
      #2;
      chk("pre_rst_ack", 32'(up_ack), 32'(1));
      chk("pre_rst_cnt", 32'(count), 32'(5));
      reset = 1'b0;
      #1;
      chk("arst_ack", 32'(up_ack), 32'(0));
      chk("arst_cnt", 32'(count), 32'(0));
      chk("arst_avail", 32'(rx_avail), 32'(0));
      chk("arst_data", 32'(rx_data), 32'(0));
      sb.delete();
      up_avail = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send_byte(8'h99, 1'b0, "post");
      chk("post_cnt", 32'(count), 32'(1));
      pop_chk("post_pop");
      chk("post_avail", 32'(rx_avail), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
